// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the adder tree result accumulator.
// Saturation build option: ADDER_TREE_ACC_SAT_EN (see acc_add_sat).
package adder_tree_pkg;

  localparam int unsigned ACC_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  // Most-positive / most-negative two's complement value of width w, right-aligned.
  function automatic logic [ACC_MAX_W-1:0] acc_sat_max(input int unsigned w);
    return (ACC_MAX_W'(1) << (w - 1)) - ACC_MAX_W'(1);
  endfunction

  function automatic logic [ACC_MAX_W-1:0] acc_sat_min(input int unsigned w);
    return ACC_MAX_W'(1) << (w - 1);
  endfunction

  // Sign-extend the low w bits of x to the full helper width.
  function automatic logic [ACC_MAX_W-1:0] sext_to_acc(input logic [ACC_MAX_W-1:0] x,
                                                       input int unsigned w);
    logic signed [ACC_MAX_W-1:0] t;
    t = signed'(x << (ACC_MAX_W - w));
    return t >>> (ACC_MAX_W - w);
  endfunction

endpackage

// File: rtl/acc_add_sat.sv
// Combinational signed adder with overflow flag.
// ADDER_TREE_ACC_SAT_EN selects saturating results; otherwise the sum wraps.
module acc_add_sat
  import adder_tree_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum_c,
  output logic         ovf_c
);

  logic [W-1:0] raw;

  assign raw   = a + b;
  assign ovf_c = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef ADDER_TREE_ACC_SAT_EN
  localparam logic [W-1:0] ACC_SAT_MAX = W'(acc_sat_max(W));
  localparam logic [W-1:0] ACC_SAT_MIN = W'(acc_sat_min(W));

  // Overflow direction follows the common operand sign.
  assign sum_c = ovf_c ? (a[W-1] ? ACC_SAT_MIN : ACC_SAT_MAX) : raw;
`else
  assign sum_c = raw;
`endif

endmodule

// File: rtl/adder_tree_accumulator.sv
// Accumulates a programmed number of adder tree partial sums and presents the total
// on a valid/ready handshake. Build option ADDER_TREE_ACC_SAT_EN enables saturation.
module adder_tree_accumulator
  import adder_tree_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 11,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_chunks,
  input  logic [IN_WIDTH-1:0]  in_sum,
  input  logic                 in_valid,
  output logic                 busy,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  output logic                 dropped
);

  if (ACC_WIDTH < IN_WIDTH || ACC_WIDTH > ACC_MAX_W || IN_WIDTH < 1) begin : g_bad_width
    $fatal(1, "adder_tree_accumulator: need IN_WIDTH <= ACC_WIDTH <= %0d", ACC_MAX_W);
  end

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;
  logic                 dropped_q, dropped_d;
  // Stray beats seen while no job can absorb them; reported in the next job's flags.
  logic                 drop_pend_q, drop_pend_d;

  logic [ACC_WIDTH-1:0] in_ext;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;

  assign in_ext = ACC_WIDTH'(sext_to_acc(ACC_MAX_W'(in_sum), IN_WIDTH));

  acc_add_sat #(.W(ACC_WIDTH)) u_add (
    .a     (acc_q),
    .b     (in_ext),
    .sum_c (add_sum),
    .ovf_c (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      dropped_q   <= 1'b0;
      drop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      dropped_q   <= dropped_d;
      drop_pend_q <= drop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    dropped_d   = dropped_q;
    drop_pend_d = drop_pend_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d       = '0;
          overflow_d  = 1'b0;
          dropped_d   = drop_pend_q | in_valid;
          drop_pend_d = 1'b0;
          if (num_chunks != '0) begin
            state_d = ACCUM;
            count_d = num_chunks;
          end else begin
            state_d     = HOLD;
            out_sum_d   = '0;
            out_valid_d = 1'b1;
          end
        end else if (in_valid) begin
          drop_pend_d = 1'b1;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d      = add_sum;
          count_d    = count_q - CNT_WIDTH'(1);
          overflow_d = overflow_q | add_ovf;
          if (count_q == CNT_WIDTH'(1)) begin
            state_d     = HOLD;
            out_sum_d   = add_sum;
            out_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // Flags are frozen while the result is presented.
        if (in_valid) drop_pend_d = 1'b1;
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign busy      = busy_q;
  assign out_sum   = out_sum_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Directed bench for adder_tree_accumulator with an expected-result queue.
module tb_adder_tree_accumulator;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
    logic        drp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, out_ready;
  logic [7:0]  num_chunks;
  logic [10:0] in_sum;
  logic        busy, out_valid, overflow, dropped;
  logic [31:0] out_sum;

  logic        start12, in_valid12, out_ready12;
  logic [7:0]  num_chunks12;
  logic [10:0] in_sum12;
  logic        busy12, out_valid12, overflow12, dropped12;
  logic [11:0] out_sum12;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  adder_tree_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks),
    .in_sum(in_sum), .in_valid(in_valid), .busy(busy), .out_sum(out_sum),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .dropped(dropped)
  );

  adder_tree_accumulator #(.IN_WIDTH(11), .ACC_WIDTH(12), .CNT_WIDTH(8)) dut12 (
    .clk(clk), .rst(rst), .start(start12), .num_chunks(num_chunks12),
    .in_sum(in_sum12), .in_valid(in_valid12), .busy(busy12), .out_sum(out_sum12),
    .out_valid(out_valid12), .out_ready(out_ready12), .overflow(overflow12),
    .dropped(dropped12)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int s, input logic o, input logic d);
    exp_t e;
    e.sum = 32'(s);
    e.ovf = o;
    e.drp = d;
    exp_q.push_back(e);
  endtask

  task automatic beat(input int v);
    in_valid = 1'b1;
    in_sum   = 11'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_job(input int n);
    start      = 1'b1;
    num_chunks = 8'(n);
    tick();
    start      = 1'b0;
  endtask

  // Wait (bounded) for a result on the main DUT and compare it to the queue head.
  task automatic wait_out(input string tag);
    exp_t e;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_qdepth"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, out_sum, e.sum);
      chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
      chk({tag, "_drp"}, 32'(dropped), 32'(e.drp));
    end
  endtask

  task automatic wait_out12(input string tag);
    exp_t e;
    for (int i = 0; i < 20 && !out_valid12; i++) tick();
    chk({tag, "_valid"}, 32'(out_valid12), 32'd1);
    chk({tag, "_qdepth"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, 32'(signed'(out_sum12)), e.sum);
      chk({tag, "_ovf"}, 32'(overflow12), 32'(e.ovf));
      chk({tag, "_drp"}, 32'(dropped12), 32'(e.drp));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    num_chunks = '0; in_sum = '0;
    start12 = 1'b0; in_valid12 = 1'b0; out_ready12 = 1'b1;
    num_chunks12 = '0; in_sum12 = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", out_sum, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drp", 32'(dropped), 32'd0);

    // Four beats on non-consecutive cycles
    push_exp(106, 1'b0, 1'b0);
    start_job(4);
    chk("j1_busy", 32'(busy), 32'd1);
    beat(10); tick();
    beat(-3); tick(); tick();
    beat(100); tick();
    chk("j1_early_valid", 32'(out_valid), 32'd0);
    beat(-1);
    chk("j1_latency", 32'(out_valid), 32'd1);
    wait_out("j1");
    tick();
    chk("j1_post_valid", 32'(out_valid), 32'd0);
    chk("j1_post_busy", 32'(busy), 32'd0);

    // Zero-chunk job held under backpressure
    out_ready = 1'b0;
    push_exp(0, 1'b0, 1'b0);
    start_job(0);
    chk("j0_latency", 32'(out_valid), 32'd1);
    wait_out("j0");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("j0_hold_valid", 32'(out_valid), 32'd1);
      chk("j0_hold_sum", out_sum, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("j0_rel_valid", 32'(out_valid), 32'd0);
    chk("j0_rel_busy", 32'(busy), 32'd0);

    // Narrow accumulator overflow
`ifdef ADDER_TREE_ACC_SAT_EN
    push_exp(2047, 1'b1, 1'b0);
`else
    push_exp(-1027, 1'b1, 1'b0);
`endif
    start12 = 1'b1; num_chunks12 = 8'd3;
    tick();
    start12 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid12 = 1'b1; in_sum12 = 11'd1023;
      tick();
    end
    in_valid12 = 1'b0;
    wait_out12("ovf12");
    tick();

    // Stray beat in IDLE is reported by the next job
    in_valid = 1'b1; in_sum = 11'd99;
    tick();
    in_valid = 1'b0;
    tick();
    push_exp(5, 1'b0, 1'b1);
    start_job(1);
    beat(5);
    wait_out("drp1");
    tick();
    push_exp(2, 1'b0, 1'b0);
    start_job(1);
    beat(2);
    wait_out("drp0");
    tick();

    // Reset mid-job aborts without output
    start_job(4);
    beat(1); beat(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    push_exp(-7, 1'b0, 1'b0);
    start_job(1);
    beat(-7);
    wait_out("abort_next");
    tick();

    // start with a same-cycle beat; a start during ACCUM is ignored
    push_exp(3, 1'b0, 1'b1);
    start = 1'b1; num_chunks = 8'd2; in_valid = 1'b1; in_sum = 11'd9;
    tick();
    num_chunks = 8'd5; in_valid = 1'b0;
    tick();
    start = 1'b0;
    beat(1);
    beat(2);
    chk("ign_latency", 32'(out_valid), 32'd1);
    wait_out("ign");
    tick();
    chk("ign_idle_busy", 32'(busy), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_tree_accumulator.md
Name: adder_tree_accumulator

Overview:
- Receiving end of the adder tree result interface: consumes the tree's signed partial sum plus its one-cycle valid pulse (the tree's start_out).
- Accumulates a programmed number of partial sums (chunks) into a wide signed total.
- Presents the total on a valid/ready handshake to the downstream consumer.
- Sits directly after the adder tree in the datapath, so vectors longer than NUM_INPUTS can be reduced over several tree passes.

Parameters:
- IN_WIDTH, 11, signed width of the incoming tree sum (tree INPUT_WIDTH + LEVELS).
- ACC_WIDTH, 32, signed width of accumulator and out_sum; must be >= IN_WIDTH (elaboration $fatal otherwise).
- CNT_WIDTH, 8, width of the chunk counter and num_chunks.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin an accumulation job; sampled only in IDLE.
- num_chunks  in  CNT_WIDTH  chunks in the job; latched on accepted start.
- in_sum  in  IN_WIDTH  signed partial sum from the tree.
- in_valid  in  1  in_sum valid this cycle; no backpressure toward the tree.
- busy  out  1  high in ACCUM and HOLD.
- out_sum  out  ACC_WIDTH  signed accumulated total.
- out_valid  out  1  total available.
- out_ready  in  1  consumer accepts out_sum.
- overflow  out  1  sticky per job; set when any add overflows ACC_WIDTH.
- dropped  out  1  sticky per job; set when in_valid arrives outside ACCUM.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are clk and rst.
- Reset state: state=IDLE; acc, count, out_sum = 0; busy, out_valid, overflow, dropped = 0.
- rst has priority over all other inputs and aborts a job in progress with no output.
- Width rule: in_sum is sign-extended to ACC_WIDTH; acc_next = acc + sext(in_sum).
- Overflow is detected when both operand signs are equal and the result sign differs.
- FSM:
  - IDLE: start=1 with num_chunks>0 -> ACCUM, acc=0, count=num_chunks, overflow=0, dropped=0.
  - IDLE: start=1 with num_chunks==0 -> HOLD with out_sum=0, out_valid=1 next cycle; overflow and dropped cleared.
  - ACCUM: each in_valid adds in_sum and decrements count. When count==1 and in_valid -> HOLD. out_sum takes the final sum and out_valid=1 on the next cycle, so latency from the last in_valid is 1 cycle.
  - HOLD: out_sum, out_valid, overflow and dropped are held stable until out_valid && out_ready -> IDLE. out_valid drops in the cycle after the handshake.
- start and in_valid in the same IDLE cycle: the job is accepted, the in_valid beat is not accumulated, and dropped=1.
- in_valid in IDLE (without start) or in HOLD: the beat is discarded and dropped=1 (visible in the current or next job's flags).
- start in ACCUM or HOLD: ignored.
- Back-to-back jobs: start is only accepted once IDLE is reached, at least 1 cycle after the handshake.
- count is CNT_WIDTH wide; the maximum job is 2^CNT_WIDTH-1 chunks, with no wrap.

Optional Feature:
- Macro: ADDER_TREE_ACC_SAT_EN.
- Defined: on overflow, acc saturates to the most-positive or most-negative ACC_WIDTH value and further adds continue from the saturated value; overflow sets.
- Undefined: acc wraps modulo 2^ACC_WIDTH; overflow still sets.
- Port list is identical in both builds.

Decomposition:
- Shared package adder_tree_pkg holds:
  - acc_state_e enum {IDLE, ACCUM, HOLD};
  - localparam ACC_SAT_MAX / ACC_SAT_MIN functions of the width;
  - function sext_to_acc.
- One sub-module, acc_add_sat: a combinational signed adder with overflow flag and macro-controlled saturation. It is instantiated once.
- The FSM, counter and output register stay in the top module.
- Flops use the team register macros with synchronous active-high reset.

Test Plan:
- start, num_chunks=4; in_sum=10,-3,100,-1 on non-consecutive cycles, out_ready=1 -> out_valid 1 cycle after 4th beat, out_sum=106, overflow=0, dropped=0, busy low after handshake.
- num_chunks=0 -> out_valid next cycle, out_sum=0; hold out_ready=0 5 cycles -> stays valid/stable; release -> IDLE.
- ACC_WIDTH=12, IN_WIDTH=11, num_chunks=3, in_sum=1023 x3:
  - with ADDER_TREE_ACC_SAT_EN -> out_sum=2047, overflow=1;
  - without -> out_sum=-1027 (wrapped 3069), overflow=1.
- in_valid=1 in IDLE, then start with num_chunks=1, in_sum=5 -> out_sum=5, dropped=1. Next job with no stray beats -> dropped=0.
- rst asserted mid-job after 2 of 4 beats -> next cycle IDLE, busy=0, out_valid=0. New job num_chunks=1, in_sum=-7 -> out_sum=-7.
- start and in_valid (in_sum=9) same cycle, num_chunks=2, then beats 1,2 -> out_sum=3, dropped=1. A start pulsed during ACCUM is ignored.
